// File: rtl/tick_meter_pkg.sv
// Shared types and default constants for the tick period meter.
// The glitch filter is enabled by TICK_PERIOD_METER_GLITCH_FILTER_EN.
package tick_meter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } MeterState;

  localparam int DEF_CNT_W    = 32;
  localparam int DEF_TIMEOUT  = 50000000;
  localparam int DEF_FILT_LEN = 4;
  localparam int SYNC_DEPTH   = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizer, optional glitch filter (TICK_PERIOD_METER_GLITCH_FILTER_EN),
// level register, arming and registered rise/fall strobes.
module sync_edge_det
  import tick_meter_pkg::*;
#(
  parameter int FILT_LEN = DEF_FILT_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic sigIn,
  output logic riseTick,
  output logic fallTick,
  output logic riseNext
);

`ifdef TICK_PERIOD_METER_GLITCH_FILTER_EN
  localparam int READY_CNT = SYNC_DEPTH + FILT_LEN + 1;
`else
  localparam int READY_CNT = SYNC_DEPTH + 1;
`endif
  localparam int READY_W = $clog2(SYNC_DEPTH + FILT_LEN + 2);

  logic [SYNC_DEPTH-1:0] syncReg;
  logic                  syncOut;
  logic                  lvl;
  logic                  lvlNext;
  logic                  armed;
  logic                  lvlReady;
  logic                  fallNext;
  logic [READY_W-1:0]    readyCnt;

  assign syncOut = syncReg[SYNC_DEPTH-1];

`ifdef TICK_PERIOD_METER_GLITCH_FILTER_EN
  localparam int RUN_W = $clog2(FILT_LEN + 1);

  logic [RUN_W-1:0] runCnt;
  logic             flip;

  // lvl follows the synchronizer only after a run of differing samples
  assign flip    = (syncOut != lvl) && (runCnt == RUN_W'(FILT_LEN));
  assign lvlNext = flip ? syncOut : lvl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      runCnt <= '0;
    end else if ((syncOut == lvl) || flip) begin
      runCnt <= '0;
    end else begin
      runCnt <= runCnt + RUN_W'(1);
    end
  end
`else
  assign lvlNext = syncOut;
`endif

  // lvl only holds a real sample once the pipeline has filled; arming waits
  // for that so a source already high at reset release never looks like a rise
  assign lvlReady = (readyCnt == READY_W'(READY_CNT));
  assign riseNext = (armed || lvlReady) && lvlNext && !lvl;
  assign fallNext = armed && !lvlNext && lvl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      syncReg  <= '0;
      lvl      <= 1'b0;
      armed    <= 1'b0;
      readyCnt <= '0;
      riseTick <= 1'b0;
      fallTick <= 1'b0;
    end else begin
      syncReg  <= {syncReg[SYNC_DEPTH-2:0], sigIn};
      lvl      <= lvlNext;
      if (!lvlReady) begin
        readyCnt <= readyCnt + READY_W'(1);
      end
      if (lvlReady && !lvl) begin
        armed <= 1'b1;
      end
      riseTick <= riseNext;
      fallTick <= fallNext;
    end
  end

endmodule

// File: rtl/tick_period_meter.sv
// Measures rise-to-rise period of a slow asynchronous input in clk cycles,
// with stall timeout. Glitch filter via TICK_PERIOD_METER_GLITCH_FILTER_EN.
module tick_period_meter
  import tick_meter_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int FILT_LEN = DEF_FILT_LEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             stalled
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  MeterState        st;
  logic [CNT_W-1:0] cnt;
  logic             riseNext;

  sync_edge_det #(
    .FILT_LEN(FILT_LEN)
  ) edgeDet (
    .clk     (clk),
    .reset   (reset),
    .sigIn   (sig_in),
    .riseTick(rise_tick),
    .fallTick(fall_tick),
    .riseNext(riseNext)
  );

  // Acting on riseNext lines period/period_valid up with the registered rise_tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st           <= IDLE;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      stalled      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      case (st)
        IDLE: begin
          if (riseNext) begin
            cnt <= CNT_W'(1);
            st  <= MEAS;
          end
        end
        MEAS: begin
          if (riseNext) begin
            period       <= cnt;
            period_valid <= 1'b1;
            cnt          <= CNT_W'(1);
            stalled      <= 1'b0;
          end else if (cnt == TIMEOUT_CNT) begin
            st      <= IDLE;
            stalled <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tick_period_meter.sv
// Scoreboard bench for tick_period_meter; expectations follow the
// TICK_PERIOD_METER_GLITCH_FILTER_EN setting of the build.
module tb_tick_period_meter;

  localparam int TO = 20;
  localparam int FL = 4;
`ifdef TICK_PERIOD_METER_GLITCH_FILTER_EN
  localparam int LAT           = 3 + FL;
  localparam bit GLITCH_PASSES = 1'b0;
`else
  localparam int LAT           = 3;
  localparam bit GLITCH_PASSES = 1'b1;
`endif

  typedef struct {
    int at;
    int val;
  } PerExp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sig_in = 1'b0;
  logic        rise_tick;
  logic        fall_tick;
  logic [31:0] period;
  logic        period_valid;
  logic        stalled;

  int    cyc = 0;
  int    total = 0;
  int    bad = 0;
  int    prevRise = -1;
  int    riseQ[$];
  int    fallQ[$];
  PerExp perQ[$];

  tick_period_meter #(
    .CNT_W   (32),
    .TIMEOUT (TO),
    .FILT_LEN(FL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sig_in      (sig_in),
    .rise_tick   (rise_tick),
    .fall_tick   (fall_tick),
    .period      (period),
    .period_valid(period_valid),
    .stalled     (stalled)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: an edge driven now shows up LAT cycles later; a rise
  // closes a measurement when the previous rise is at most TO cycles back
  task automatic expectEdge(input bit rising, input int at);
    if (rising) begin
      riseQ.push_back(at);
      if (prevRise >= 0 && (at - prevRise) <= TO) begin
        perQ.push_back('{at, at - prevRise});
      end
      prevRise = at;
    end else begin
      fallQ.push_back(at);
    end
  endtask

  task automatic applyStimulus(input bit v, input int hold, input bit expEdge);
    sig_in = v;
    if (expEdge) expectEdge(v, cyc + LAT);
    repeat (hold) step();
  endtask

  task automatic assertReset(input bit lvlDuring, input int cycles);
    reset  = 1'b0;
    sig_in = lvlDuring;
    riseQ.delete();
    fallQ.delete();
    perQ.delete();
    prevRise = -1;
    #1;
    checkOutput("resetPeriod", period, 0);
    checkOutput("resetValid", period_valid, 0);
    checkOutput("resetStalled", stalled, 0);
    checkOutput("resetRise", rise_tick, 0);
    checkOutput("resetFall", fall_tick, 0);
    repeat (cycles) step();
    reset = 1'b1;
  endtask

  // Scoreboard: every strobe the DUT raises must match the next expectation
  always @(negedge clk) begin
    PerExp e;
    if (rise_tick && fall_tick) checkOutput("exclusive", 1, 0);
    if (rise_tick) begin
      if (riseQ.size() == 0) checkOutput("riseUnexpected", cyc, -1);
      else checkOutput("riseCycle", cyc, riseQ.pop_front());
    end
    if (fall_tick) begin
      if (fallQ.size() == 0) checkOutput("fallUnexpected", cyc, -1);
      else checkOutput("fallCycle", cyc, fallQ.pop_front());
    end
    if (period_valid) begin
      if (perQ.size() == 0) begin
        checkOutput("validUnexpected", cyc, -1);
      end else begin
        e = perQ.pop_front();
        checkOutput("validCycle", cyc, e.at);
        checkOutput("periodValue", period, e.val);
        checkOutput("stalledAtValid", stalled, 0);
      end
    end
  end

  initial begin
    int stallAt;
    reset = 1'b0;
    step();
    assertReset(1'b0, 3);
    applyStimulus(1'b0, 10, 1'b0);

    // steady toggle, 5 high / 5 low
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 5, 1'b1);
      applyStimulus(1'b0, 5, 1'b1);
    end

    // stall: no edges after the last rise
    stallAt = prevRise + TO;
    while (cyc < stallAt - 1) step();
    checkOutput("stalledEarly", stalled, 0);
    step();
    checkOutput("stalledSet", stalled, 1);
    checkOutput("periodKept", period, 10);
    step();

    // two rises 12 apart clear the stall, then a rise exactly at the timeout
    applyStimulus(1'b1, 6, 1'b1);
    applyStimulus(1'b0, 6, 1'b1);
    checkOutput("stalledHeld", stalled, 1);
    applyStimulus(1'b1, 10, 1'b1);
    applyStimulus(1'b0, 10, 1'b1);
    checkOutput("stalledCleared", stalled, 0);
    applyStimulus(1'b1, 10, 1'b1);
    applyStimulus(1'b0, 5, 1'b1);
    checkOutput("stalledAtTimeoutRise", stalled, 0);
    checkOutput("periodTimeout", period, TO);

    // reset 7 cycles into a measurement
    applyStimulus(1'b1, 5, 1'b1);
    applyStimulus(1'b0, 0, 1'b1);
    while (cyc < prevRise + 7) step();
    assertReset(1'b0, 3);
    applyStimulus(1'b0, 10, 1'b0);
    applyStimulus(1'b1, 5, 1'b1);
    applyStimulus(1'b0, 5, 1'b1);
    applyStimulus(1'b1, 5, 1'b1);
    applyStimulus(1'b0, 5, 1'b1);

    // input already high at reset release: first fall and rise are suppressed
    assertReset(1'b1, 3);
    applyStimulus(1'b1, 12, 1'b0);
    applyStimulus(1'b0, 6, 1'b0);
    applyStimulus(1'b1, 5, 1'b1);
    applyStimulus(1'b0, 5, 1'b1);
    applyStimulus(1'b1, 5, 1'b1);
    applyStimulus(1'b0, 30, 1'b1);

    // 2-cycle glitch, then a clean 6-cycle pulse
    applyStimulus(1'b1, 2, GLITCH_PASSES);
    applyStimulus(1'b0, 10, GLITCH_PASSES);
    applyStimulus(1'b1, 6, 1'b1);
    applyStimulus(1'b0, 12, 1'b1);

    repeat (LAT + 2) step();
    checkOutput("riseLeft", riseQ.size(), 0);
    checkOutput("fallLeft", fallQ.size(), 0);
    checkOutput("validLeft", perQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
